instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 22 ++
 rtl/instruction_fetch.sv | 109 ++++++++++
 tb/tb_instruction_fetch.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface instruction_fetch_if;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_resp,
    input  imem_rdata
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_resp,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one outstanding memory read, presents the fetched
// word to the hazard unit and follows redirects, discarding stale responses.
//
// state   | meaning
// S_REQ   | read outstanding for req_addr, result will be kept
// S_VALID | instruction in ir_reg presented, waiting for pc_ld
// S_DRAIN | read outstanding for an abandoned address, result will be dropped
module instruction_fetch (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pc_ld,
  input  logic                       hold,
  input  logic                       redirect,
  input  logic [15:0]                redirect_pc,
  instruction_fetch_if.master        imem,
  output logic [15:0]                ir_val,
  output logic [15:0]                pc_out,
  output logic                       stall,
  output logic [15:0]                fetch_count,
  output logic [15:0]                drop_count
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] req_addr;
  logic [15:0] ir_reg;
  logic [15:0] ir_pc;
  logic [15:0] target;
  logic [15:0] next_seq;

  assign target   = redirect_pc & 16'hFFFE;
  assign next_seq = ir_pc + 16'd2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= 16'h0000;
      req_addr    <= 16'h0000;
      ir_reg      <= 16'h0000;
      ir_pc       <= 16'h0000;
      fetch_count <= 16'h0000;
      drop_count  <= 16'h0000;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect) begin
            pc <= target;
            if (imem.imem_resp) begin
              drop_count <= drop_count + 16'd1;
              req_addr   <= target;
            end else begin
              state <= S_DRAIN;
            end
          end else if (imem.imem_resp) begin
            ir_reg <= imem.imem_rdata;
            ir_pc  <= req_addr;
            state  <= S_VALID;
          end
        end
        S_DRAIN: begin
          // A redirect in the same cycle as the stale response wins over pc.
          if (imem.imem_resp) begin
            drop_count <= drop_count + 16'd1;
            state      <= S_REQ;
            if (redirect) begin
              pc       <= target;
              req_addr <= target;
            end else begin
              req_addr <= pc;
            end
          end else if (redirect) begin
            pc <= target;
          end
        end
        S_VALID: begin
          if (redirect) begin
            pc       <= target;
            req_addr <= target;
            state    <= S_REQ;
          end else if (hold) begin
            state <= S_VALID;
          end else if (pc_ld) begin
            pc          <= next_seq;
            req_addr    <= next_seq;
            fetch_count <= fetch_count + 16'd1;
            state       <= S_REQ;
          end
        end
        default: begin
          state    <= S_REQ;
          req_addr <= pc;
        end
      endcase
    end
  end

  assign imem.imem_read    = (state != S_VALID);
  assign imem.imem_address = req_addr;
  assign stall             = (state != S_VALID);
  assign ir_val            = (state == S_VALID) ? ir_reg : 16'h0000;
  assign pc_out            = ir_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by a
// randomized phase checked by a program-flow reference model and scoreboard.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_ld;
  logic        hold;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] ir_val;
  logic [15:0] pc_out;
  logic        stall;
  logic [15:0] fetch_count;
  logic [15:0] drop_count;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pc_ld       (pc_ld),
    .hold        (hold),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .ir_val      (ir_val),
    .pc_out      (pc_out),
    .stall       (stall),
    .fetch_count (fetch_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state (random phase)
  logic [15:0] exp_q[$];
  logic [15:0] fetch_exp = 16'h0;
  logic [15:0] drop_exp = 16'h0;
  logic        stale = 1'b0;
  int          lat = 0;
  logic        rand_on = 1'b0;
  logic        prev_valid = 1'b0;
  int          n_valid = 0;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a ^ 16'h5A3C) + {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: retires consumed instructions and checks each cycle.
  always @(posedge clk) begin
    if (rand_on) begin
      #1;
      if (prev_valid && !reset && !redirect && !hold && pc_ld) begin
        if (exp_q.size() > 0) begin
          logic [15:0] a;
          a = exp_q.pop_front();
          exp_q.push_back(a + 16'd2);
          fetch_exp = fetch_exp + 16'd1;
        end
      end
      if (!stall) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rnd_unexpected: got pc %h with no expected instruction", pc_out);
        end else begin
          chk("rnd_pc_out", pc_out, exp_q[0]);
          chk("rnd_ir_val", ir_val, memf(exp_q[0]));
        end
        chk("rnd_read_in_valid", {15'd0, bus.imem_read}, 16'd0);
      end else begin
        chk("rnd_ir_stall", ir_val, 16'h0000);
        chk("rnd_read_in_stall", {15'd0, bus.imem_read}, 16'd1);
      end
      chk("rnd_fetch_count", fetch_count, fetch_exp);
      chk("rnd_drop_count", drop_count, drop_exp);
      prev_valid = !stall;
    end
  end

  initial begin
    reset = 1'b1; pc_ld = 1'b0; hold = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    bus.imem_resp = 1'b0; bus.imem_rdata = 16'h0;
    tick; tick;
    reset = 1'b0;
    chk("rst_read", {15'd0, bus.imem_read}, 16'd1);
    chk("rst_addr", bus.imem_address, 16'h0000);
    chk("rst_stall", {15'd0, stall}, 16'd1);
    chk("rst_ir", ir_val, 16'h0000);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_fetch", fetch_count, 16'h0000);
    chk("rst_drop", drop_count, 16'h0000);

    // first fetch, single-cycle latency
    bus.imem_resp = 1'b1; bus.imem_rdata = 16'h1234; pc_ld = 1'b1;
    tick;
    chk("f1_stall", {15'd0, stall}, 16'd0);
    chk("f1_ir", ir_val, 16'h1234);
    chk("f1_pc_out", pc_out, 16'h0000);
    bus.imem_resp = 1'b0;
    tick;
    chk("f1_next_addr", bus.imem_address, 16'h0002);
    chk("f1_fetch", fetch_count, 16'd1);

    // bubble insertion: same instruction for three cycles
    bus.imem_resp = 1'b1; bus.imem_rdata = 16'hBEEF; pc_ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      bus.imem_resp = 1'b0;
      chk("bub_stall", {15'd0, stall}, 16'd0);
      chk("bub_ir", ir_val, 16'hBEEF);
      chk("bub_pc_out", pc_out, 16'h0002);
    end
    pc_ld = 1'b1;
    tick;
    chk("bub_addr", bus.imem_address, 16'h0004);
    chk("bub_fetch", fetch_count, 16'd2);

    // redirect with same-cycle response, then redirect into drain
    pc_ld = 1'b0; redirect = 1'b1; redirect_pc = 16'h0010; bus.imem_resp = 1'b1;
    tick;
    chk("rd_addr10", bus.imem_address, 16'h0010);
    chk("rd_drop1", drop_count, 16'd1);
    bus.imem_resp = 1'b0; redirect_pc = 16'h0101;
    tick;
    redirect = 1'b0;
    chk("drain_addr_a", bus.imem_address, 16'h0010);
    chk("drain_stall", {15'd0, stall}, 16'd1);
    tick;
    chk("drain_addr_b", bus.imem_address, 16'h0010);
    bus.imem_resp = 1'b1; bus.imem_rdata = 16'h9999;
    tick;
    chk("drain_next_addr", bus.imem_address, 16'h0100);
    chk("drain_drop", drop_count, 16'd2);
    chk("drain_stall2", {15'd0, stall}, 16'd1);
    bus.imem_rdata = 16'h5555;
    tick;
    bus.imem_resp = 1'b0;
    chk("drain_pc_out", pc_out, 16'h0100);
    chk("drain_ir", ir_val, 16'h5555);

    // priority: redirect beats hold and pc_ld; hold alone freezes
    hold = 1'b1; pc_ld = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
    tick;
    chk("pri_addr", bus.imem_address, 16'h0200);
    chk("pri_fetch", fetch_count, 16'd2);
    redirect = 1'b0; bus.imem_resp = 1'b1; bus.imem_rdata = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      tick;
      bus.imem_resp = 1'b0;
      chk("hold_ir", ir_val, 16'h7777);
      chk("hold_pc_out", pc_out, 16'h0200);
      chk("hold_fetch", fetch_count, 16'd2);
    end
    hold = 1'b0;
    tick;
    chk("hold_rel_addr", bus.imem_address, 16'h0202);
    chk("hold_rel_fetch", fetch_count, 16'd3);

    // PC wraps past 0xFFFE
    pc_ld = 1'b0; redirect = 1'b1; redirect_pc = 16'hFFFE; bus.imem_resp = 1'b1;
    tick;
    chk("wrap_addr", bus.imem_address, 16'hFFFE);
    redirect = 1'b0; bus.imem_rdata = 16'h1111; pc_ld = 1'b1;
    tick;
    bus.imem_resp = 1'b0;
    chk("wrap_pc_out", pc_out, 16'hFFFE);
    tick;
    chk("wrap_next_addr", bus.imem_address, 16'h0000);
    chk("wrap_fetch", fetch_count, 16'd4);

    // reset while draining, then a late response is the 0x0000 fetch
    pc_ld = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
    tick;
    chk("rsd_drain_addr", bus.imem_address, 16'h0000);
    redirect = 1'b0; reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rsd_addr", bus.imem_address, 16'h0000);
    chk("rsd_drop", drop_count, 16'd0);
    chk("rsd_stall", {15'd0, stall}, 16'd1);
    bus.imem_resp = 1'b1; bus.imem_rdata = 16'h2222;
    tick;
    bus.imem_resp = 1'b0;
    chk("late_ir", ir_val, 16'h2222);
    chk("late_pc_out", pc_out, 16'h0000);
    chk("late_drop", drop_count, 16'd0);

    // drop counter wrap
    reset = 1'b1;
    tick;
    reset = 1'b0; redirect = 1'b1; redirect_pc = 16'h0300; bus.imem_resp = 1'b1;
    for (int i = 0; i < 65535; i++) tick;
    chk("dwrap_ffff", drop_count, 16'hFFFF);
    chk("dwrap_addr", bus.imem_address, 16'h0300);
    tick;
    chk("dwrap_zero", drop_count, 16'h0000);
    redirect = 1'b0; bus.imem_resp = 1'b0;

    // randomized phase
    @(posedge clk); #2;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc == 0) begin
        reset = 1'b1;
        rand_on = 1'b1;
      end else begin
        reset = ($urandom_range(0, 299) == 0);
      end
      redirect = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 16'hFFFE;
        1:       redirect_pc = 16'hFFFF;
        default: redirect_pc = 16'($urandom);
      endcase
      hold  = ($urandom_range(0, 3) == 0);
      pc_ld = ($urandom_range(0, 2) != 0);
      bus.imem_resp = 1'b0;
      if (bus.imem_read) begin
        if (lat == 0) begin
          bus.imem_resp  = 1'b1;
          bus.imem_rdata = memf(bus.imem_address);
          lat = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end
      if (reset) begin
        exp_q.delete();
        exp_q.push_back(16'h0000);
        fetch_exp = 16'h0;
        drop_exp  = 16'h0;
        stale     = 1'b0;
      end else begin
        // a response is stale if its request was superseded by a redirect
        if (bus.imem_resp) begin
          if (stale || redirect) drop_exp = drop_exp + 16'd1;
          stale = 1'b0;
        end else if (redirect && bus.imem_read) begin
          stale = 1'b1;
        end
        if (redirect) begin
          exp_q.delete();
          exp_q.push_back(redirect_pc & 16'hFFFE);
        end
      end
      @(posedge clk); #2;
    end
    rand_on = 1'b0;
    chk("rnd_liveness", {15'd0, n_valid > 300}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
